// File: rtl/mul_norm_round.sv
// Normalise, round (nearest-even) and pack a raw 24x24 single-precision mantissa product.
// A small FSM walks each product through IDLE -> NORM -> ROUND -> DONE, one result at a time.
module mul_norm_round (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_in_s,
  input  logic [9:0]  i_in_e,
  input  logic [47:0] i_in_m,
  input  logic        i_in_nan,
  input  logic        i_in_inf,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_output
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             r_state;
  logic [47:0]        r_m;
  logic signed [9:0]  r_e;
  logic               r_s;
  logic               r_sticky;
  logic               r_nan;
  logic               r_inf;
  logic               r_zero;
  logic [31:0]        r_output;
  logic               r_out_valid;

  logic [22:0]        w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic               w_inc;
  logic [23:0]        w_mant_sum;
  logic signed [10:0] w_e_rnd;
  logic [31:0]        w_packed;

  // Exponent is widened by one bit so a rounding carry at the top of the range cannot wrap.
  always_comb begin
    w_mant     = r_m[45:23];
    w_guard    = r_m[22];
    w_sticky   = (|r_m[21:0]) | r_sticky;
    w_inc      = w_guard & (w_sticky | w_mant[0]);
    w_mant_sum = {1'b0, w_mant} + {23'd0, w_inc};
    w_e_rnd    = $signed({r_e[9], r_e}) + $signed({10'd0, w_mant_sum[23]});
    w_packed   = {r_s, w_e_rnd[7:0], w_mant_sum[22:0]};
    if (r_nan)
      w_packed = 32'h7FC0_0000;
    else if (r_inf)
      w_packed = {r_s, 8'hFF, 23'd0};
    else if (r_zero)
      w_packed = {r_s, 31'd0};
    else if (w_e_rnd >= 11'sd255)
      w_packed = {r_s, 8'hFF, 23'd0};
    else if (w_e_rnd <= 11'sd0)
      w_packed = {r_s, 31'd0};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_m         <= '0;
      r_e         <= '0;
      r_s         <= 1'b0;
      r_sticky    <= 1'b0;
      r_nan       <= 1'b0;
      r_inf       <= 1'b0;
      r_zero      <= 1'b0;
      r_output    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_m      <= i_in_m;
            r_e      <= $signed(i_in_e);
            r_s      <= i_in_s;
            r_nan    <= i_in_nan;
            r_inf    <= i_in_inf;
            r_sticky <= 1'b0;
            r_zero   <= 1'b0;
            r_state  <= NORM;
          end
        end
        NORM: begin
          // Specials bypass shifting; otherwise one normalisation step per cycle.
          if (r_nan || r_inf) begin
            r_state <= ROUND;
          end else if (r_m[47]) begin
            r_m      <= {1'b0, r_m[47:1]};
            r_e      <= r_e + 10'sd1;
            r_sticky <= r_sticky | r_m[0];
            r_state  <= ROUND;
          end else if (r_m[46]) begin
            r_state <= ROUND;
          end else if (r_m == 48'd0) begin
            r_zero  <= 1'b1;
            r_state <= ROUND;
          end else begin
            r_m <= {r_m[46:0], 1'b0};
            r_e <= r_e - 10'sd1;
          end
        end
        ROUND: begin
          r_output    <= w_packed;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = r_out_valid;
  assign o_output    = r_output;

endmodule

// File: tb/tb_mul_norm_round.sv
// Directed-vector bench for mul_norm_round: packed results, latency, backpressure, specials and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic        inS;
  logic [9:0]  inE;
  logic [47:0] inM;
  logic        inNan;
  logic        inInf;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;

  int errorCount = 0;
  int checkCount = 0;

  logic [31:0] result;
  int          latency;
  int          badCount;

  always #5 clk = ~clk;

  mul_norm_round dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_in_s      (inS),
    .i_in_e      (inE),
    .i_in_m      (inM),
    .i_in_nan    (inNan),
    .i_in_inf    (inInf),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_output    (outData)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Latency counts rising edges from the accept edge to the edge where downstream first sees out_valid.
  task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [47:0] m,
                               input logic nan, input logic inf,
                               output logic [31:0] res, output int lat);
    int k;
    @(negedge clk);
    inS = s; inE = e; inM = m; inNan = nan; inInf = inf; inValid = 1'b1;
    k = 0;
    while (!inReady && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    k = 0;
    while (!outValid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) checkOutput("valid_timeout", 0, 1);
    lat = k + 1;
    res = outData;
  endtask

  task automatic completeHandshake(input string tag);
    @(negedge clk);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput({tag, "_valid_drop"}, outValid, 0);
    checkOutput({tag, "_ready_back"}, inReady, 1);
  endtask

  task automatic runVector(input string tag, input logic s, input logic [9:0] e, input logic [47:0] m,
                           input logic nan, input logic inf, input logic [31:0] expected);
    applyStimulus(s, e, m, nan, inf, result, latency);
    checkOutput(tag, result, expected);
    completeHandshake(tag);
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inS = 1'b0; inE = '0; inM = '0;
    inNan = 1'b0; inInf = 1'b0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_output", outData, 32'h0000_0000);
    checkOutput("reset_in_ready", inReady, 1);
    rst = 1'b0;

    applyStimulus(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, result, latency);
    checkOutput("mul_1p5_sq", result, 32'h4010_0000);
    checkOutput("mul_1p5_latency", latency, 3);
    completeHandshake("mul_1p5");

    runVector("one",        1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 32'h3F80_0000);
    runVector("ovf_pos",    1'b0, 10'd255, 48'h4000_0000_0000, 1'b0, 1'b0, 32'h7F80_0000);
    runVector("ovf_neg",    1'b1, 10'd255, 48'h4000_0000_0000, 1'b0, 1'b0, 32'hFF80_0000);
    runVector("underflow",  1'b0, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b0, 32'h0000_0000);
    runVector("tie_odd",    1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 32'h3F80_0002);
    runVector("tie_even",   1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 32'h3F80_0000);
    runVector("mant_carry", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 32'h4000_0000);
    runVector("zero_m",     1'b0, 10'd127, 48'h0000_0000_0000, 1'b0, 1'b0, 32'h0000_0000);

    applyStimulus(1'b0, 10'd127, 48'h1000_0000_0000, 1'b0, 1'b0, result, latency);
    checkOutput("two_shift", result, 32'h3E80_0000);
    checkOutput("two_shift_latency", latency, 5);
    completeHandshake("two_shift");

    applyStimulus(1'b0, 10'd127, 48'h4000_0000_0000, 1'b1, 1'b1, result, latency);
    checkOutput("nan", result, 32'h7FC0_0000);
    checkOutput("nan_latency", latency, 3);
    completeHandshake("nan");
    runVector("inf_neg", 1'b1, 10'd127, 48'h0000_0000_0001, 1'b0, 1'b1, 32'hFF80_0000);

    // Hold the result in DONE while upstream keeps offering a different product.
    applyStimulus(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, result, latency);
    checkOutput("bp_first", result, 32'h4010_0000);
    badCount = 0;
    inS = 1'b1; inE = 10'd0; inM = 48'h4000_0000_0000;
    for (int i = 0; i < 10; i++) begin
      inValid = i[0];
      @(negedge clk);
      if (outData !== 32'h4010_0000 || inReady !== 1'b0 || outValid !== 1'b1) badCount++;
    end
    inValid = 1'b0;
    checkOutput("bp_stable", badCount, 0);
    completeHandshake("bp");
    repeat (3) @(negedge clk);
    checkOutput("bp_output_hold", outData, 32'h4010_0000);
    checkOutput("bp_no_stray_valid", outValid, 0);

    // Reset in the middle of a long left-shift sequence discards the operation.
    @(negedge clk);
    inS = 1'b0; inE = 10'd127; inM = 48'h0000_0100_0000; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_busy", inReady, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ready", inReady, 1);
    checkOutput("midrst_output_clear", outData, 32'h0000_0000);
    badCount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (outValid !== 1'b0 || inReady !== 1'b1) badCount++;
    end
    checkOutput("midrst_no_valid", badCount, 0);
    runVector("after_rst_one", 1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 32'h3F80_0000);

    // Reset wins over a simultaneous in_valid.
    @(negedge clk);
    inM = 48'h4000_0000_0000; inValid = 1'b1; rst = 1'b1;
    @(negedge clk);
    inValid = 1'b0; rst = 1'b0;
    badCount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (outValid !== 1'b0 || inReady !== 1'b1) badCount++;
    end
    checkOutput("rst_beats_valid", badCount, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mul_norm_round.md
MUL_NORM_ROUND -- requirements
Module: mul_norm_round

Interface
REQ-001 SHALL have no parameters; all widths fixed for IEEE-754 single precision.
REQ-002 SHALL use one clock and a synchronous active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-003 in_valid  input  1  upstream product valid.
REQ-004 in_ready  output 1  block can accept a product.
REQ-005 in_s  input  1  result sign (sgA xor sgB).
REQ-006 in_e  input  10  two's-complement biased exponent, expA+expB-127.
REQ-007 in_m  input  48  raw 24x24 mantissa product, hidden bits included.
REQ-008 in_nan / in_inf  input  1 each  upstream special-case flags; in_nan has priority.
REQ-009 out_valid  output 1  packed result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 Output  output 32  packed float {sign, exp[7:0], man[22:0]}.

Function
REQ-012 FSM states are IDLE, NORM, ROUND and DONE; in_ready is 1 only in IDLE.
REQ-013 In IDLE, in_valid=1 at edge T SHALL capture all inputs and move to NORM.
- Inputs are ignored when in_ready=0.
REQ-014 In NORM, one action per cycle, in priority order:
- m[47]=1 -> shift m right by 1, e+1, OR the lost bit into sticky, go to ROUND.
- m[46]=1 -> go to ROUND.
- m==0 -> set zero flag, go to ROUND.
- otherwise -> shift m left by 1, e-1, stay in NORM.
REQ-015 In NORM, e SHALL be held in 10-bit signed arithmetic with no wrap in the legal range; at most 46 left shifts can occur.
REQ-016 In ROUND, the fields SHALL be:
- mantissa = m[45:23]
- guard = m[22]
- sticky = |m[21:0] OR the captured sticky bit.
REQ-017 Rounding SHALL be round-to-nearest-even: increment when guard & (sticky | mantissa[0]).
- A carry out of mantissa sets mantissa=0 and e+1.
REQ-018 Output SHALL be selected in priority order:
- nan -> 0x7FC00000
- inf -> {s, 0xFF, 0}
- zero flag -> {s, 0}
- e>=255 after rounding -> {s, 0xFF, 0}
- e<=0 -> {s, 0} (flush, no subnormal outputs)
- else -> {s, e[7:0], mantissa}
REQ-019 A nan/inf input SHALL skip NORM shifting and take one NORM cycle, then ROUND.
REQ-020 ROUND SHALL register Output, assert out_valid and go to DONE.
REQ-021 Latency: accept at T with the product already normalized (or m[47] set) -> out_valid at T+3.
- Each left shift adds one cycle.
REQ-022 In DONE, Output and out_valid SHALL hold stable until out_ready=1.
- The handshake edge returns the FSM to IDLE with out_valid=0; a new accept is possible the next cycle.
- No back-to-back overlap: throughput is at most one result per 4 cycles.
REQ-023 out_ready is don't-care outside DONE; Output SHALL hold its last value while out_valid=0.

Reset
REQ-024 rst=1 at an edge SHALL force:
- state=IDLE
- in_ready=1 on the following cycle
- out_valid=0
- Output=0x00000000
- internal m, e, sticky and flags cleared.
REQ-025 Reset asserted in any state (including mid-NORM or DONE with out_ready=0) SHALL discard the operation in flight; no out_valid for it follows.
REQ-026 Reset SHALL take priority over a simultaneous in_valid; that input is not captured.

Verification
REQ-027 in_m=0x900000000000, in_e=127, s=0 (1.5*1.5) -> Output=0x40100000, out_valid at T+3.
REQ-028 in_m=0x400000000000 with in_e=127/255/0:
- in_e=127 -> 0x3F800000
- in_e=255 -> 0x7F800000
- in_e=0 -> 0x00000000
- the in_e=255 case with s=1 -> 0xFF800000
REQ-029 Rounding, in_e=127:
- in_m=0x400000C00000 -> 0x3F800002 (tie, odd, round up)
- in_m=0x400000400000 -> 0x3F800000 (tie, even)
- in_m=0x7FFFFFC00000 -> 0x40000000 (mantissa carry)
REQ-030 in_m=0x100000000000, in_e=127 -> two left shifts, Output=0x3E800000 at T+5; in_m=0 -> 0x00000000.
REQ-031 Backpressure and specials:
- hold out_ready=0 for 10 cycles in DONE -> Output stable, in_ready=0, in_valid pulses ignored.
- in_nan=1 -> 0x7FC00000.
- in_inf=1, s=1 -> 0xFF800000.
REQ-032 Reset mid-operation: rst during NORM of a shifting input -> out_valid stays 0, in_ready=1 the cycle after rst deasserts, and the next op (1.0*1.0) returns 0x3F800000.
